simd_prefix_adder_pipe: RTL

- Parametrised, 2-stage pipelined grouped Brent-Kung prefix adder/subtractor with valid/ready handshakes on input and output.
- Adds an add/sub mode, a SIMD lane mode that breaks the carry chain at lane boundaries, and per-lane carry-out and overflow flags.
- A zero flag is also produced.
- Sits between the execute-stage operand muxes and the ALU result mux; it is the ALU's adder datapath.

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/prefix_tree_bk.sv | 37 +++
 rtl/simd_prefix_adder_pipe.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and helpers for the SIMD prefix adder: lane-mode encoding and
// the per-group lane-boundary mask used to segment the carry chain.
package alu_pkg;

    typedef enum logic [1:0] {
        LANE_X1 = 2'd0,
        LANE_X2 = 2'd1,
        LANE_X4 = 2'd2
    } lane_mode_e;

    localparam int MAX_LANES = 4;
    localparam int MAX_NG    = 256;

    function automatic lane_mode_e decode_lane_mode(input logic [1:0] raw);
        lane_mode_e mode;
        case (raw)
            2'd1:    mode = LANE_X2;
            2'd2:    mode = LANE_X4;
            default: mode = LANE_X1;
        endcase
        return mode;
    endfunction

    function automatic int lane_count(input lane_mode_e mode);
        int n;
        case (mode)
            LANE_X2: n = 2;
            LANE_X4: n = 4;
            default: n = 1;
        endcase
        return n;
    endfunction

    // Bit i is set when group i is the least-significant group of a lane.
    function automatic logic [MAX_NG-1:0] boundary_mask(input lane_mode_e mode, input int ng);
        logic [MAX_NG-1:0] m;
        int per;
        m   = '0;
        per = ng / lane_count(mode);
        for (int i = 0; i < MAX_NG; i++) begin
            if ((i < ng) && ((i % per) == 0)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/prefix_tree_bk.sv
// Combinational Brent-Kung prefix over group (P, G) pairs. Groups flagged in
// kill have their propagate cleared so no carry crosses into them from below.
module prefix_tree_bk #(
    parameter int NG = 8
) (
    input  logic [NG-1:0] p_in,
    input  logic [NG-1:0] g_in,
    input  logic [NG-1:0] kill,
    output logic [NG-1:0] carry
);

    localparam int LEVELS = $clog2(NG);

    logic [NG-1:0] g_w;
    logic [NG-1:0] p_w;

    always_comb begin
        g_w = g_in;
        p_w = p_in & ~kill;
        // Up-sweep: node i at each level absorbs the span just below it.
        for (int d = 0; d < LEVELS; d++) begin
            for (int i = (2 << d) - 1; i < NG; i += (2 << d)) begin
                g_w[i] = g_w[i] | (p_w[i] & g_w[i - (1 << d)]);
                p_w[i] = p_w[i] & p_w[i - (1 << d)];
            end
        end
        // Down-sweep fills the remaining positions from completed spans.
        for (int d = LEVELS - 2; d >= 0; d--) begin
            for (int i = (3 << d) - 1; i < NG; i += (2 << d)) begin
                g_w[i] = g_w[i] | (p_w[i] & g_w[i - (1 << d)]);
                p_w[i] = p_w[i] & p_w[i - (1 << d)];
            end
        end
        carry = g_w;
    end

endmodule

// File: rtl/simd_prefix_adder_pipe.sv
// Two-stage pipelined SIMD add/sub datapath: stage 1 forms bit and group P/G,
// stage 2 runs the segmented prefix tree and registers sum and lane flags.
module simd_prefix_adder_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int GROUP = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_cin,
    input  logic                 in_sub,
    input  logic [1:0]           in_lane_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_result,
    output logic [MAX_LANES-1:0] out_cout,
    output logic [MAX_LANES-1:0] out_ovf,
    output logic                 out_zero
);

    localparam int NG = WIDTH / GROUP;

    logic rdy1, rdy2, load1, load2;

    logic             v1_q, v1_d;
    logic [WIDTH-1:0] p_q, p_d, g_q, g_d;
    logic [NG-1:0]    gp_q, gp_d, gg_q, gg_d;
    lane_mode_e       mode_q, mode_d;
    logic             sub_q, sub_d, cin0_q, cin0_d;

    logic                 v2_q, v2_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [MAX_LANES-1:0] cout_q, cout_d, ovf_q, ovf_d;
    logic                 zero_q, zero_d;

    logic [WIDTH-1:0]  b_x;
    logic              grp_g, grp_p;
    logic [MAX_NG-1:0] mask_full;
    logic [NG-1:0]     kill, lcin, g_fold, gc;
    logic [NG:0]       gc_ext;
    logic [WIDTH-1:0]  sum, c_into;
    logic              c_run;
    int                nl, lw, msb;

    // A stage may load when it is empty or its contents move on this cycle.
    always_comb begin
        rdy2     = !v2_q || out_ready;
        rdy1     = !v1_q || rdy2;
        in_ready = rdy1;
        load1    = in_valid && rdy1;
        load2    = v1_q && rdy2;
    end

    always_comb begin
        b_x    = in_b ^ {WIDTH{in_sub}};
        grp_g  = 1'b0;
        grp_p  = 1'b1;
        v1_d   = rdy1 ? in_valid : v1_q;
        p_d    = p_q;
        g_d    = g_q;
        gp_d   = gp_q;
        gg_d   = gg_q;
        mode_d = mode_q;
        sub_d  = sub_q;
        cin0_d = cin0_q;
        if (load1) begin
            p_d    = in_a ^ b_x;
            g_d    = in_a & b_x;
            mode_d = decode_lane_mode(in_lane_mode);
            sub_d  = in_sub;
            cin0_d = in_sub | in_cin;
            for (int j = 0; j < NG; j++) begin
                grp_g = 1'b0;
                grp_p = 1'b1;
                for (int b = 0; b < GROUP; b++) begin
                    grp_g = g_d[j*GROUP + b] | (p_d[j*GROUP + b] & grp_g);
                    grp_p = grp_p & p_d[j*GROUP + b];
                end
                gp_d[j] = grp_p;
                gg_d[j] = grp_g;
            end
        end
    end

    // Lane carry-in is folded into the boundary group's generate; the tree
    // then kills propagate there so lower lanes cannot leak upward.
    always_comb begin
        mask_full = boundary_mask(mode_q, NG);
        kill      = mask_full[NG-1:0];
        for (int j = 0; j < NG; j++) begin
            lcin[j]   = (j == 0) ? cin0_q : sub_q;
            g_fold[j] = gg_q[j] | (kill[j] & gp_q[j] & lcin[j]);
        end
    end

    prefix_tree_bk #(
        .NG(NG)
    ) u_tree (
        .p_in (gp_q),
        .g_in (g_fold),
        .kill (kill),
        .carry(gc)
    );

    always_comb begin
        gc_ext = {gc, 1'b0};
        c_run  = 1'b0;
        sum    = '0;
        c_into = '0;
        for (int j = 0; j < NG; j++) begin
            c_run = kill[j] ? lcin[j] : gc_ext[j];
            for (int b = 0; b < GROUP; b++) begin
                sum[j*GROUP + b]    = p_q[j*GROUP + b] ^ c_run;
                c_into[j*GROUP + b] = c_run;
                c_run = g_q[j*GROUP + b] | (p_q[j*GROUP + b] & c_run);
            end
        end
    end

    always_comb begin
        nl       = lane_count(mode_q);
        lw       = WIDTH / nl;
        msb      = 0;
        v2_d     = rdy2 ? v1_q : v2_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        if (load2) begin
            result_d = sum;
            zero_d   = (sum == '0);
            cout_d   = '0;
            ovf_d    = '0;
            // The carry out of a lane's MSB is the prefix carry of its top group.
            for (int k = 0; k < MAX_LANES; k++) begin
                if (k < nl) begin
                    msb       = (k + 1) * lw - 1;
                    cout_d[k] = gc[msb / GROUP];
                    ovf_d[k]  = gc[msb / GROUP] ^ c_into[msb];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q     <= 1'b0;
            p_q      <= '0;
            g_q      <= '0;
            gp_q     <= '0;
            gg_q     <= '0;
            mode_q   <= LANE_X1;
            sub_q    <= 1'b0;
            cin0_q   <= 1'b0;
            v2_q     <= 1'b0;
            result_q <= '0;
            cout_q   <= '0;
            ovf_q    <= '0;
            zero_q   <= 1'b0;
        end else begin
            v1_q     <= v1_d;
            p_q      <= p_d;
            g_q      <= g_d;
            gp_q     <= gp_d;
            gg_q     <= gg_d;
            mode_q   <= mode_d;
            sub_q    <= sub_d;
            cin0_q   <= cin0_d;
            v2_q     <= v2_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign out_valid  = v2_q;
    assign out_result = result_q;
    assign out_cout   = cout_q;
    assign out_ovf    = ovf_q;
    assign out_zero   = zero_q;

endmodule
